// File: rtl/sdram_req_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_req_arbiter_pkg: shared FSM encoding, default widths, clog2 helper.
// Revision: 1.0
// ---------------------------------------------------------------------------
package sdram_req_arbiter_pkg;

    localparam int DEF_AW = 23;
    localparam int DEF_DW = 32;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_SETTLE = 2'd2
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sdram_tag_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_tag_fifo: in-order FIFO of requester tags for outstanding reads.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sdram_tag_fifo
    import sdram_req_arbiter_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TW    = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   push,
    input  logic                   pop,
    input  logic [TW-1:0]          din,
    output logic [TW-1:0]          dout,
    output logic [clog2(DEPTH):0]  count,
    output logic                   empty,
    output logic                   full
);

    localparam int PW = clog2(DEPTH);

    logic [TW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;
    logic          w_push;
    logic          w_pop;

    assign empty  = (count_q == '0);
    assign full   = (count_q == (PW + 1)'(DEPTH));
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;
    assign dout   = mem_q[rd_ptr_q];
    assign count  = count_q;

    // Storage needs no reset: a slot is only read after it has been written.
    always_ff @(posedge clk) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (w_pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_q <= count_q + (PW + 1)'(1);
                2'b01:   count_q <= count_q - (PW + 1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/sdram_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sdram_req_arbiter: round-robin sharing of the SDRAM controller user port,
// with paced issue and in-order routing of read responses. Revision: 1.0
// ---------------------------------------------------------------------------
module sdram_req_arbiter
    import sdram_req_arbiter_pkg::*;
#(
    parameter int NREQ      = 2,
    parameter int TAG_DEPTH = 4,
    parameter int AW        = DEF_AW,
    parameter int DW        = DEF_DW
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREQ-1:0]           req_valid,
    output logic [NREQ-1:0]           req_ready,
    input  logic [NREQ-1:0]           req_rw,
    input  logic [NREQ*AW-1:0]        req_addr,
    input  logic [NREQ*DW-1:0]        req_wdata,
    output logic [NREQ-1:0]           rsp_valid,
    output logic [DW-1:0]             rsp_rdata,
    output logic [AW-1:0]             ctl_addr,
    output logic                      ctl_rw,
    output logic [DW-1:0]             ctl_wdata,
    output logic                      ctl_in_valid,
    input  logic                      ctl_busy,
    input  logic                      ctl_out_valid,
    input  logic [DW-1:0]             ctl_rdata,
    output logic [clog2(TAG_DEPTH):0] rd_pending,
    output logic                      err_spurious
);

    localparam int TW = (NREQ > 1) ? clog2(NREQ) : 1;

    state_t          state_q;
    logic [TW-1:0]   rr_ptr_q;
    logic [AW-1:0]   ctl_addr_q;
    logic            ctl_rw_q;
    logic [DW-1:0]   ctl_wdata_q;
    logic            ctl_in_valid_q;
    logic [NREQ-1:0] rsp_valid_q;
    logic [NREQ-1:0] rsp_valid_d;
    logic [DW-1:0]   rsp_rdata_q;
    logic            err_spurious_q;

    logic [NREQ-1:0] w_elig;
    logic            w_found;
    logic [TW-1:0]   w_grant;
    logic            w_fire;
    logic [AW-1:0]   w_sel_addr;
    logic            w_sel_rw;
    logic [DW-1:0]   w_sel_wdata;
    logic            w_push;
    logic            w_pop;
    logic [TW-1:0]   w_head_tag;
    logic            w_tag_empty;
    logic            w_tag_full;

    // A full tag FIFO blocks reads only; writes never need a tag.
    always_comb begin
        w_elig = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_elig[i] = req_valid[i] && (req_rw[i] || !w_tag_full);
        end
    end

    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_grant = '0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NREQ;
            if (!w_found && w_elig[idx]) begin
                w_found = 1'b1;
                w_grant = TW'(idx);
            end
        end
    end

    assign w_fire = (state_q == S_IDLE) && !ctl_busy && w_found;

    always_comb begin
        req_ready   = '0;
        w_sel_addr  = '0;
        w_sel_rw    = 1'b0;
        w_sel_wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant == TW'(i)) begin
                req_ready[i] = w_fire;
                w_sel_addr   = req_addr[i*AW +: AW];
                w_sel_rw     = req_rw[i];
                w_sel_wdata  = req_wdata[i*DW +: DW];
            end
        end
    end

    assign w_push = w_fire && !w_sel_rw;
    assign w_pop  = ctl_out_valid && !w_tag_empty;

    always_comb begin
        rsp_valid_d = '0;
        for (int i = 0; i < NREQ; i++) begin
            rsp_valid_d[i] = w_pop && (w_head_tag == TW'(i));
        end
    end

    sdram_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .TW    (TW)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_grant),
        .dout  (w_head_tag),
        .count (rd_pending),
        .empty (w_tag_empty),
        .full  (w_tag_full)
    );

    // ISSUE and SETTLE space grants three cycles apart so the controller's
    // registered busy is current whenever IDLE samples it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            rr_ptr_q       <= TW'(NREQ - 1);
            ctl_addr_q     <= '0;
            ctl_rw_q       <= 1'b0;
            ctl_wdata_q    <= '0;
            ctl_in_valid_q <= 1'b0;
            rsp_valid_q    <= '0;
            rsp_rdata_q    <= '0;
            err_spurious_q <= 1'b0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            if (w_pop) begin
                rsp_rdata_q <= ctl_rdata;
            end
            if (ctl_out_valid && w_tag_empty) begin
                err_spurious_q <= 1'b1;
            end
            case (state_q)
                S_IDLE: begin
                    if (w_fire) begin
                        ctl_addr_q     <= w_sel_addr;
                        ctl_rw_q       <= w_sel_rw;
                        ctl_wdata_q    <= w_sel_wdata;
                        ctl_in_valid_q <= 1'b1;
                        rr_ptr_q       <= w_grant;
                        state_q        <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    ctl_in_valid_q <= 1'b0;
                    state_q        <= S_SETTLE;
                end
                S_SETTLE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    ctl_in_valid_q <= 1'b0;
                    state_q        <= S_IDLE;
                end
            endcase
        end
    end

    assign ctl_addr     = ctl_addr_q;
    assign ctl_rw       = ctl_rw_q;
    assign ctl_wdata    = ctl_wdata_q;
    assign ctl_in_valid = ctl_in_valid_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign err_spurious = err_spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_sdram_req_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_sdram_req_arbiter: directed and randomized checks against a queue model.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_sdram_req_arbiter;

    localparam int NREQ = 2;
    localparam int TD   = 4;
    localparam int AW   = 23;
    localparam int DW   = 32;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ-1:0]      req_rw;
    logic [NREQ*AW-1:0]   req_addr;
    logic [NREQ*DW-1:0]   req_wdata;
    logic [NREQ-1:0]      rsp_valid;
    logic [DW-1:0]        rsp_rdata;
    logic [AW-1:0]        ctl_addr;
    logic                 ctl_rw;
    logic [DW-1:0]        ctl_wdata;
    logic                 ctl_in_valid;
    logic                 ctl_busy;
    logic                 ctl_out_valid;
    logic [DW-1:0]        ctl_rdata;
    logic [2:0]           rd_pending;
    logic                 err_spurious;

    always #5 clk = ~clk;

    sdram_req_arbiter #(
        .NREQ(NREQ), .TAG_DEPTH(TD), .AW(AW), .DW(DW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
        .ctl_addr(ctl_addr), .ctl_rw(ctl_rw), .ctl_wdata(ctl_wdata),
        .ctl_in_valid(ctl_in_valid), .ctl_busy(ctl_busy),
        .ctl_out_valid(ctl_out_valid), .ctl_rdata(ctl_rdata),
        .rd_pending(rd_pending), .err_spurious(err_spurious)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: issue gap counter, last winner, queue of read owners.
    int              m_rr;
    int              m_gap;
    int              m_q[$];
    logic [AW-1:0]   m_addr;
    logic            m_rw;
    logic [DW-1:0]   m_wdata;
    logic            m_inv;
    logic [NREQ-1:0] m_rsp;
    logic [DW-1:0]   m_rdata;
    logic            m_err;
    int              dut_grant;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_rr = NREQ - 1; m_gap = 3; m_q.delete();
        m_addr = '0; m_rw = 1'b0; m_wdata = '0; m_inv = 1'b0;
        m_rsp = '0; m_rdata = '0; m_err = 1'b0;
    endtask

    task automatic set_req(input int i, input logic rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_valid[i]          = 1'b1;
        req_rw[i]             = rw;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Called at posedge+1 with inputs already set for the coming cycle.
    task automatic cycle();
        logic [NREQ-1:0] exp_ready;
        int g;
        int t;
        #1;
        exp_ready = '0;
        g = -1;
        if (m_gap >= 3 && !ctl_busy) begin
            for (int k = 1; k <= NREQ; k++) begin
                int idx;
                idx = (m_rr + k) % NREQ;
                if (g < 0 && req_valid[idx] && (req_rw[idx] || m_q.size() < TD)) g = idx;
            end
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        chk("req_ready", req_ready, exp_ready);
        dut_grant = -1;
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) dut_grant = i;
        m_rsp = '0;
        if (ctl_out_valid) begin
            if (m_q.size() > 0) begin
                t = m_q.pop_front();
                m_rsp[t] = 1'b1;
                m_rdata = ctl_rdata;
            end else begin
                m_err = 1'b1;
            end
        end
        if (g >= 0) begin
            m_addr  = req_addr[g*AW +: AW];
            m_rw    = req_rw[g];
            m_wdata = req_wdata[g*DW +: DW];
            m_inv   = 1'b1;
            m_rr    = g;
            m_gap   = 1;
            if (!req_rw[g]) m_q.push_back(g);
        end else begin
            m_inv = 1'b0;
            if (m_gap < 3) m_gap++;
        end
        @(posedge clk);
        #1;
        chk("ctl_in_valid", ctl_in_valid, m_inv);
        chk("ctl_addr", ctl_addr, m_addr);
        chk("ctl_rw", ctl_rw, m_rw);
        chk("ctl_wdata", ctl_wdata, m_wdata);
        chk("rsp_valid", rsp_valid, m_rsp);
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rd_pending", rd_pending, m_q.size());
        chk("err_spurious", err_spurious, m_err);
    endtask

    task automatic wait_grant(input int i, input string tag);
        logic seen;
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            cycle();
            if (dut_grant == i) seen = 1'b1;
        end
        req_valid[i] = 1'b0;
        chk(tag, seen, 1'b1);
    endtask

    task automatic drain();
        req_valid = '0;
        ctl_busy  = 1'b0;
        for (int k = 0; k < 24; k++) begin
            ctl_out_valid = (m_q.size() > 0);
            ctl_rdata     = $urandom;
            cycle();
        end
        ctl_out_valid = 1'b0;
        chk("drain_pending", rd_pending, 0);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_valid"}, ctl_in_valid, 0);
        chk({tag, "_addr"}, ctl_addr, 0);
        chk({tag, "_rw"}, ctl_rw, 0);
        chk({tag, "_wdata"}, ctl_wdata, 0);
        chk({tag, "_rsp_valid"}, rsp_valid, 0);
        chk({tag, "_rsp_rdata"}, rsp_rdata, 0);
        chk({tag, "_err"}, err_spurious, 0);
        chk({tag, "_pending"}, rd_pending, 0);
        chk({tag, "_ready"}, req_ready, 0);
    endtask

    initial begin
        int prev;
        int ngr;
        rst_n = 1'b0; req_valid = '0; req_rw = '0; req_addr = '0; req_wdata = '0;
        ctl_busy = 1'b0; ctl_out_valid = 1'b0; ctl_rdata = '0;
        model_reset();
        #3;
        check_reset("por");
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Single write
        set_req(0, 1'b1, 23'h000100, 32'hDEADBEEF);
        cycle();
        chk("t1_grant", dut_grant, 0);
        req_valid = '0;
        chk("t1_in_valid", ctl_in_valid, 1);
        chk("t1_addr", ctl_addr, 23'h000100);
        chk("t1_wdata", ctl_wdata, 32'hDEADBEEF);
        chk("t1_rw", ctl_rw, 1);
        cycle();
        chk("t1_in_valid_drop", ctl_in_valid, 0);
        chk("t1_no_rsp", rsp_valid, 0);
        cycle(); cycle();

        // Round-robin between two continuous readers
        set_req(0, 1'b0, 23'h10, '0);
        set_req(1, 1'b0, 23'h20, '0);
        prev = -1; ngr = 0;
        for (int k = 0; k < 60; k++) begin
            ctl_busy      = ($urandom % 3 == 0);
            ctl_out_valid = (m_q.size() > 0) && ($urandom % 2 == 0);
            ctl_rdata     = $urandom;
            cycle();
            if (dut_grant >= 0) begin
                if (prev >= 0) chk("t2_alternate", dut_grant, 1 - prev);
                prev = dut_grant;
                ngr++;
            end
        end
        chk("t2_enough_grants", ngr >= 4, 1);
        drain();

        // Read routing by tag order
        set_req(1, 1'b0, 23'h400, '0);
        wait_grant(1, "t3_grant1");
        cycle(); cycle();
        set_req(0, 1'b0, 23'h800, '0);
        wait_grant(0, "t3_grant0");
        cycle(); cycle();
        ctl_out_valid = 1'b1; ctl_rdata = 32'h11111111;
        cycle();
        ctl_out_valid = 1'b0;
        chk("t3_rsp1_valid", rsp_valid, 2'b10);
        chk("t3_rsp1_data", rsp_rdata, 32'h11111111);
        cycle();
        chk("t3_rsp1_pulse", rsp_valid, 2'b00);
        ctl_out_valid = 1'b1; ctl_rdata = 32'h22222222;
        cycle();
        ctl_out_valid = 1'b0;
        chk("t3_rsp0_valid", rsp_valid, 2'b01);
        chk("t3_rsp0_data", rsp_rdata, 32'h22222222);
        cycle();
        chk("t3_rdata_hold", rsp_rdata, 32'h22222222);

        // Tag FIFO full: reads stall, writes still pass
        set_req(0, 1'b0, 23'h30, '0);
        ngr = 0;
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (dut_grant == 0) ngr++;
        end
        chk("t4_reads_issued", ngr, 4);
        chk("t4_pending_full", rd_pending, 4);
        set_req(1, 1'b1, 23'h40, 32'h0000CAFE);
        wait_grant(1, "t4_write_granted");
        cycle(); cycle(); cycle();
        chk("t4_read_stalled", dut_grant + 1, 0);
        ctl_out_valid = 1'b1; ctl_rdata = 32'h33333333;
        cycle();
        ctl_out_valid = 1'b0;
        chk("t4_pop_rsp", rsp_valid, 2'b01);
        wait_grant(0, "t4_read_after_pop");
        drain();

        // Spurious response
        ctl_out_valid = 1'b1; ctl_rdata = 32'h44444444;
        cycle();
        ctl_out_valid = 1'b0;
        chk("t5_no_rsp", rsp_valid, 0);
        chk("t5_err_set", err_spurious, 1);
        cycle(); cycle(); cycle();
        chk("t5_err_sticky", err_spurious, 1);

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (dut_grant == i) req_valid[i] = 1'b0;
                if (!req_valid[i] && ($urandom % 2 == 0))
                    set_req(i, 1'($urandom % 2), AW'($urandom), $urandom);
            end
            ctl_busy      = ($urandom % 4 == 0);
            ctl_out_valid = ((m_q.size() > 0) && ($urandom % 3 == 0)) || ($urandom % 60 == 0);
            ctl_rdata     = $urandom;
            cycle();
        end
        drain();

        // Async reset with two reads pending
        set_req(0, 1'b0, 23'h1234, '0);
        wait_grant(0, "t6_read0");
        set_req(1, 1'b0, 23'h5678, '0);
        wait_grant(1, "t6_read1");
        cycle();
        chk("t6_pending_two", rd_pending, 2);
        #1 rst_n = 1'b0;
        #1;
        model_reset();
        check_reset("t6_rst");
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        ctl_out_valid = 1'b1; ctl_rdata = 32'h55555555;
        cycle();
        ctl_out_valid = 1'b0;
        chk("t6_inflight_err", err_spurious, 1);
        chk("t6_inflight_no_rsp", rsp_valid, 0);
        set_req(0, 1'b1, 23'h0007, 32'h77);
        cycle();
        chk("t6_idle_after_reset", dut_grant, 0);
        req_valid = '0;
        cycle(); cycle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_req_arbiter.md
Name: sdram_req_arbiter

Overview:
- Shares the single user port of the SDRAM controller (queue-of-1, busy / in_valid / out_valid interface) between NREQ requesters.
- Sits between the bus-side requesters (e.g. Wishbone slave, prefetch/DMA engine) and the controller.
- Arbitrates round-robin and paces issue to respect the controller's registered busy.
- Keeps an in-order read-tag FIFO so each read response returns to the requester that issued it.

Parameters:
- NREQ, 2, number of requesters (2..4).
- TAG_DEPTH, 4, read-tag FIFO depth (power of 2); maximum outstanding reads.
- AW, 23, address width.
- DW, 32, data width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  request pending, one bit per requester.
- req_ready  out  NREQ  request accepted this cycle (combinational, one-hot or zero).
- req_rw  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*AW  flattened; requester i at [i*AW +: AW].
- req_wdata  in  NREQ*DW  flattened write data.
- rsp_valid  out  NREQ  one-cycle read-data pulse to the owning requester.
- rsp_rdata  out  DW  read data, shared by all requesters, qualified by rsp_valid.
- ctl_addr  out  AW  to controller user_addr.
- ctl_rw  out  1  to controller rw.
- ctl_wdata  out  DW  to controller data_in.
- ctl_in_valid  out  1  to controller in_valid.
- ctl_busy  in  1  from controller busy.
- ctl_out_valid  in  1  from controller out_valid.
- ctl_rdata  in  DW  from controller data_out.
- rd_pending  out  log2(TAG_DEPTH)+1  outstanding read count.
- err_spurious  out  1  sticky flag: ctl_out_valid arrived while the tag FIFO was empty.

Behaviour:
- Reset (async, rst_n=0) sets:
  - state=S_IDLE, all FIFO pointers/count=0, rr_ptr=NREQ-1.
  - ctl_in_valid=0, ctl_addr=0, ctl_rw=0, ctl_wdata=0.
  - rsp_valid=0, rsp_rdata=0, err_spurious=0.
  - req_ready is 0 because state is not S_IDLE-granting.
- Eligibility: requester i is eligible when req_valid[i] && (req_rw[i] || tag_count<TAG_DEPTH).
  - Writes are never blocked by a full FIFO.
- Grant: the first eligible index searching rr_ptr+1, rr_ptr+2, … modulo NREQ.
- FSM:
  - S_IDLE: if !ctl_busy and any requester is eligible:
    - req_ready[g]=1 (combinational).
    - Register ctl_addr/ctl_rw/ctl_wdata from requester g and set ctl_in_valid<=1.
    - rr_ptr<=g.
    - If it is a read, push tag g.
    - Next state S_ISSUE.
    - Otherwise stay.
  - S_ISSUE: ctl_in_valid=1 for exactly this cycle; the controller latches here. Clear ctl_in_valid at the edge. Next state S_SETTLE.
  - S_SETTLE: ignore ctl_busy, which is stale/registered, for one cycle. Next state S_IDLE.
- Issue spacing: minimum 3 cycles between grants, so in_valid is never asserted in consecutive or stale-busy cycles.
- ctl_addr/ctl_rw/ctl_wdata hold their values until the next grant.
- Read response:
  - When ctl_out_valid=1 and the FIFO is non-empty: pop the head tag t.
  - Next cycle: rsp_valid[t]=1 and rsp_rdata=ctl_rdata as captured, for 1 cycle.
  - Latency: 1 cycle from ctl_out_valid.
  - rsp_rdata holds its value until the next response.
- Spurious response (ctl_out_valid with the FIFO empty): no rsp_valid, no pop; err_spurious<=1, sticky until reset.
- Simultaneous push and pop: both take effect and tag_count is unchanged.
- The full check uses tag_count before the pop (conservative; a same-cycle pop does not unblock a read).
- Pointer arithmetic wraps modulo TAG_DEPTH. tag_count is one bit wider than the pointers.
- rd_pending = tag_count.
- Reset mid-operation:
  - All tags are discarded.
  - Responses the controller still has in flight are reported via err_spurious.
  - Reset both blocks together.
- Requesters must hold req_valid/addr/data/rw stable until req_ready is seen (no retraction); the arbiter does not check this.

Decomposition:
- Shared package:
  - FSM state encoding (S_IDLE, S_ISSUE, S_SETTLE).
  - Default AW/DW.
  - Tag-width function clog2.
- One sub-module: sdram_tag_fifo.
  - Synchronous FIFO of log2(NREQ)-bit tags, depth TAG_DEPTH, async active-low reset.
  - Ports: push/pop/din/dout/count/empty/full.

Test Plan:
- Single write: req0 write addr 0x000100, data 0xDEADBEEF, ctl_busy=0 -> req_ready[0] in the request cycle; ctl_in_valid high exactly one cycle later with ctl_addr=0x000100, ctl_wdata=0xDEADBEEF, ctl_rw=1; no rsp_valid.
- Round-robin: req0 and req1 both hold valid reads (addr 0x10, 0x20) continuously -> grants alternate 0,1,0,1; issues ≥3 cycles apart; each grant waits for ctl_busy=0.
- Read routing: req1 reads 0x400 then req0 reads 0x800; model returns 0x11111111 then 0x22222222 -> rsp_valid[1] with 0x11111111 first, then rsp_valid[0] with 0x22222222, each 1 cycle after ctl_out_valid.
- FIFO full: with TAG_DEPTH=4, responses withheld -> 4 reads issue and a 5th read stalls (rd_pending=4); a concurrent write from the other requester is still granted; one ctl_out_valid then lets the read issue.
- Spurious: ctl_out_valid pulsed with rd_pending=0 -> no rsp_valid; err_spurious=1 and it stays set until rst_n low.
- Async reset mid-read: rst_n asserted with 2 reads pending, deasserted between clock edges -> all outputs return to reset values immediately; rd_pending=0; state S_IDLE.
